dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning the byte-address width of the data memory (512 bytes).
REQ-002 SHALL have ports Clk input 1 (rising-edge clock) and Reset input 1 (asynchronous reset, active-high).
REQ-003 SHALL have ports A_Req input 1, A_RW input 1, A_SE input 1, A_Size input 2, A_Addr input ADDR_W, A_WData input 32: port A request, with RW=1 meaning write.
REQ-004 SHALL have ports A_Ack output 1, A_RData output 32, A_Err output 1: port A response.
REQ-005 SHALL have ports B_Req, B_RW, B_SE, B_Size, B_Addr, B_WData, B_Ack, B_RData, B_Err, identical to port A.
REQ-006 SHALL have memory-side outputs MemEnable 1, MemReadWrite 1, MemSE 1, MemSize 2, MemAddress ADDR_W, MemDataIn 32, and memory-side input MemDataOut 32.
REQ-007 SHALL have output Busy 1, high whenever the FSM is not in IDLE.

Function
REQ-008 SHALL implement a 3-state FSM with states IDLE, ISSUE and RESP.
REQ-009 IDLE: if any Req is high, SHALL latch the winner's RW/SE/Size/Addr/WData and the grant ID, then go to ISSUE; otherwise SHALL stay in IDLE.
REQ-010 ISSUE: SHALL hold MemEnable=1 for exactly one cycle, drive the latched fields on the Mem* outputs, sample MemDataOut into the winner's RData register at the cycle end, then go to RESP.
REQ-011 RESP: SHALL pulse the winner's Ack high for exactly one cycle, then go to IDLE.
REQ-012 Latency: Req sampled in IDLE on edge N gives MemEnable in cycle N+1 and Ack in cycle N+2; each access occupies 3 cycles.
REQ-013 Requester SHALL hold Req and its fields stable until Ack; the arbiter SHALL ignore field changes after latching.
REQ-014 Req still high in the IDLE cycle after Ack SHALL be treated as a new request.
REQ-015 Arbitration SHALL be round-robin via a LastGrant bit: on simultaneous Req the port not granted last wins; a lone Req always wins.
REQ-016 The non-granted requester SHALL see Ack=0 and keep its RData unchanged.
REQ-017 Outside ISSUE, MemEnable SHALL be 0, and MemReadWrite, MemSE, MemSize, MemAddress and MemDataIn SHALL hold their last values.
REQ-018 On writes, RData of the winner SHALL be unchanged and Ack SHALL still pulse.
REQ-019 Size 2'b11 SHALL be forwarded unchanged: memory treats it as a word read, and as a write with no effect.
REQ-020 Each RData SHALL be a register updated only in ISSUE for its own port; Err SHALL be valid only while Ack=1 and 0 otherwise.

Reset
REQ-021 Reset high SHALL asynchronously force the FSM to IDLE and clear all Mem* outputs, both Ack, both Err, both RData and Busy to 0, and set LastGrant to B.
REQ-022 Reset during ISSUE or RESP SHALL abort the access with no Ack; MemEnable SHALL drop immediately.
REQ-023 After Reset falls, the first arbitration SHALL start on the next rising edge.

Configuration
REQ-024 Macro DMEM_ARB_ALIGN_CHECK_EN defined: a latched request SHALL be misaligned if Size=01 and Addr[0]=1, or Size[1]=1 and Addr[1:0]!=0.
REQ-025 With DMEM_ARB_ALIGN_CHECK_EN, a misaligned request SHALL go IDLE->RESP with MemEnable never asserted, and Ack=1, Err=1, RData=0 in the RESP cycle (2-cycle access).
REQ-026 Without DMEM_ARB_ALIGN_CHECK_EN, both Err outputs SHALL be tied 0 and every request SHALL follow the normal ISSUE path.

Verification
REQ-027 A write: A_Req, RW=1, Size=10, Addr=0x010, WData=0xDEADBEEF -> MemEnable high in cycle N+1 with MemAddress=0x010, MemDataIn=0xDEADBEEF; A_Ack in N+2.
REQ-028 A read-back: Size=00, SE=1, Addr=0x010 -> A_RData=0xFFFFFFDE; with SE=0 -> 0x000000DE; Size=01, SE=1 -> 0xFFFFDEAD.
REQ-029 A and B request simultaneously from reset, both held -> grant order A, B, A, B; each Ack 3 cycles apart; non-winner Ack stays 0.
REQ-030 With macro: B, Size=10, Addr=0x013 -> B_Ack and B_Err high in cycle N+1, MemEnable never high, B_RData=0; without macro -> normal access, Err=0.
REQ-031 Reset asserted mid-cycle during ISSUE -> MemEnable, Busy and Ack drop at once; FSM in IDLE; pending Req re-granted on the first edge after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter giving two requesters (A, B) turns on one data memory.
// Latency: Req seen in IDLE -> MemEnable next cycle -> Ack the cycle after (3 cycles/access).
// Backpressure: requesters hold Req until Ack. Optional macro DMEM_ARB_ALIGN_CHECK_EN adds misalignment errors.
module dmem_arbiter #(
  parameter int ADDR_W = 9
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              A_Req,
  input  logic              A_RW,
  input  logic              A_SE,
  input  logic [1:0]        A_Size,
  input  logic [ADDR_W-1:0] A_Addr,
  input  logic [31:0]       A_WData,
  output logic              A_Ack,
  output logic [31:0]       A_RData,
  output logic              A_Err,
  input  logic              B_Req,
  input  logic              B_RW,
  input  logic              B_SE,
  input  logic [1:0]        B_Size,
  input  logic [ADDR_W-1:0] B_Addr,
  input  logic [31:0]       B_WData,
  output logic              B_Ack,
  output logic [31:0]       B_RData,
  output logic              B_Err,
  output logic              MemEnable,
  output logic              MemReadWrite,
  output logic              MemSE,
  output logic [1:0]        MemSize,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [31:0]       MemDataIn,
  input  logic [31:0]       MemDataOut,
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;            // 0 = A, 1 = B
  logic                last_grant_q, last_grant_d;  // port granted most recently
  logic                mem_rw_q, mem_rw_d;
  logic                mem_se_q, mem_se_d;
  logic [1:0]          mem_size_q, mem_size_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         a_rdata_q, a_rdata_d;
  logic [31:0]         b_rdata_q, b_rdata_d;

  logic                any_req;
  logic                win_b;
  logic                win_rw;
  logic                win_se;
  logic [1:0]          win_size;
  logic [ADDR_W-1:0]   win_addr;
  logic [31:0]         win_wdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic                err_q, err_d;

  // Halfwords need an even address; words (and size 11) need a 4-byte aligned address.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == 2'b01) && a[0]) || (size[1] && (a != 2'b00));
  endfunction
`endif

  // Pick the winner: a lone request wins; on a tie the port not granted last time wins.
  always_comb begin
    any_req   = A_Req | B_Req;
    win_b     = B_Req & (~A_Req | ~last_grant_q);
    win_rw    = win_b ? B_RW    : A_RW;
    win_se    = win_b ? B_SE    : A_SE;
    win_size  = win_b ? B_Size  : A_Size;
    win_addr  = win_b ? B_Addr  : A_Addr;
    win_wdata = win_b ? B_WData : A_WData;
  end

  // Next-state logic: latch the winner in IDLE, capture read data in ISSUE, acknowledge in RESP.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_rw_d     = mem_rw_q;
    mem_se_d     = mem_se_q;
    mem_size_d   = mem_size_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d      = win_b;
          last_grant_d = win_b;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
          err_d        = misaligned(win_size, win_addr[1:0]);
          if (misaligned(win_size, win_addr[1:0])) begin
            // Memory is never touched; the Mem* outputs keep their previous values.
            state_d = RESP;
            if (win_b) b_rdata_d = '0;
            else       a_rdata_d = '0;
          end else begin
            state_d     = ISSUE;
            mem_rw_d    = win_rw;
            mem_se_d    = win_se;
            mem_size_d  = win_size;
            mem_addr_d  = win_addr;
            mem_wdata_d = win_wdata;
          end
`else
          state_d     = ISSUE;
          mem_rw_d    = win_rw;
          mem_se_d    = win_se;
          mem_size_d  = win_size;
          mem_addr_d  = win_addr;
          mem_wdata_d = win_wdata;
`endif
        end
      end
      ISSUE: begin
        // Only reads update the winner's read-data register.
        if (!mem_rw_q) begin
          if (grant_q) b_rdata_d = MemDataOut;
          else         a_rdata_d = MemDataOut;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_rw_q     <= 1'b0;
      mem_se_q     <= 1'b0;
      mem_size_q   <= 2'b00;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mem_rw_q     <= mem_rw_d;
      mem_se_q     <= mem_se_d;
      mem_size_q   <= mem_size_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      err_q        <= err_d;
`endif
    end
  end

  // Outputs decoded from state so that reset removes enable and acks immediately.
  always_comb begin
    MemEnable    = (state_q == ISSUE);
    Busy         = (state_q != IDLE);
    A_Ack        = (state_q == RESP) && !grant_q;
    B_Ack        = (state_q == RESP) &&  grant_q;
    MemReadWrite = mem_rw_q;
    MemSE        = mem_se_q;
    MemSize      = mem_size_q;
    MemAddress   = mem_addr_q;
    MemDataIn    = mem_wdata_q;
    A_RData      = a_rdata_q;
    B_RData      = b_rdata_q;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    A_Err        = A_Ack & err_q;
    B_Err        = B_Ack & err_q;
`else
    A_Err        = 1'b0;
    B_Err        = 1'b0;
`endif
  end

endmodule
